// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount arbiter.
// Holds the FSM state enum, the SUM_W sizing helper and popcnt_f().
package popcount_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_RESP
    } state_t;

    // Widest vector popcnt_f accepts; callers zero-extend into it.
    localparam int PC_MAX_W = 64;

    // Bits needed to hold a count of 0..in_w.
    function automatic int sum_w_f(input int in_w);
        return $clog2(in_w + 1);
    endfunction

    localparam int PC_SUM_W = sum_w_f(PC_MAX_W);

    function automatic logic [PC_SUM_W-1:0] popcnt_f(
        input logic [PC_MAX_W-1:0] vec
    );
        logic [PC_SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < PC_MAX_W; i++) begin
            s = s + PC_SUM_W'(vec[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Ports: req (request vector), ptr (first index to examine),
//        grant (one-hot winner), idx (binary winner), any (some req set).
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/popcount_share_arb.sv
// One registered popcount unit shared by NUM_REQ requesters, round-robin.
// Ports: clk, reset_n (async, active-low); req_valid/req_data/req_ready
//        (per-requester handshake, data packed i*IN_W); rsp_valid/rsp_ready,
//        rsp_id, rsp_sum; rsp_total only when POPCNT_ACCUM_EN is defined.
module popcount_share_arb
    import popcount_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int IN_W    = 5,
    parameter  int ID_W    = 2,
    parameter  int ACC_W   = 8,
    localparam int SUM_W   = sum_w_f(IN_W)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SUM_W-1:0]        rsp_sum
`ifdef POPCNT_ACCUM_EN
    ,
    output logic [ACC_W-1:0]        rsp_total
`endif
);

    if (ID_W < $clog2(NUM_REQ) || IN_W > PC_MAX_W || ACC_W < 1) begin : g_bad_cfg
        $error("popcount_share_arb: bad parameter set");
    end

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  lat_id;
    logic [IN_W-1:0]  lat_data;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [IN_W-1:0]  pick_data;
    logic [SUM_W-1:0] calc_sum;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_data = req_data[int'(pick_idx)*IN_W +: IN_W];
    assign calc_sum  = SUM_W'(popcnt_f(PC_MAX_W'(lat_data)));
    // Grant is only offered while idle; held low during reset.
    assign req_ready = (reset_n && state == ST_IDLE) ? pick_grant : '0;
    assign next_ptr  = (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;

`ifdef POPCNT_ACCUM_EN
    logic [ACC_W-1:0] acc [NUM_REQ];
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_new;

    assign acc_sum = {1'b0, acc[lat_id]} + (ACC_W+1)'(calc_sum);
    assign acc_new = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            lat_id    <= '0;
            lat_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
`ifdef POPCNT_ACCUM_EN
            rsp_total <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                acc[i] <= '0;
            end
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        lat_data <= pick_data;
                        lat_id   <= pick_idx;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rsp_sum   <= calc_sum;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
`ifdef POPCNT_ACCUM_EN
                    acc[lat_id] <= acc_new;
                    rsp_total   <= acc_new;
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_share_arb.sv
// Randomised and directed bench for popcount_share_arb.
// Build with +define+POPCNT_ACCUM_EN to also cover rsp_total.
module tb_popcount_share_arb;

    localparam int N  = 4;
    localparam int W  = 5;
`ifdef POPCNT_ACCUM_EN
    localparam int AW = 3;
`else
    localparam int AW = 8;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0] req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [2:0]   rsp_sum;
`ifdef POPCNT_ACCUM_EN
    logic [AW-1:0] rsp_total;
`endif

    popcount_share_arb #(
        .NUM_REQ (N),
        .IN_W    (W),
        .ID_W    (2),
        .ACC_W   (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef POPCNT_ACCUM_EN
        ,
        .rsp_total (rsp_total)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference: where the one outstanding job is.
    // 0 = none, 1 = accepted and being summed, 2 = result offered.
    int phase = 0;
    int m_ptr = 0;
    int m_id  = 0;
    int m_sum = 0;
    int m_tot [N];
    int last_g = -1;
    int cyc = 0;
    int gq[$];
    int gt[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic int ones(input logic [W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < W; i++) c += int'(v[i]);
        return c;
    endfunction

    // Check the current cycle's outputs, advance the model across the
    // coming rising edge, then wait for the next falling edge.
    task automatic tick();
        int w;
        logic [N-1:0] er;
        #1;
        last_g = -1;
        w  = winner();
        er = (phase == 0 && w >= 0) ? N'(1 << w) : '0;
        check("req_ready", 32'(req_ready), 32'(er));
        check("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
        if (phase == 2) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
`ifdef POPCNT_ACCUM_EN
            check("rsp_total", 32'(rsp_total), 32'(m_tot[m_id]));
`endif
        end
        if (phase == 0) begin
            if (w >= 0) begin
                m_id   = w;
                m_sum  = ones(req_data[w*W +: W]);
                phase  = 1;
                last_g = w;
                gq.push_back(w);
                gt.push_back(cyc);
            end
        end else if (phase == 1) begin
            m_tot[m_id] = m_tot[m_id] + m_sum;
            if (m_tot[m_id] > (1 << AW) - 1) m_tot[m_id] = (1 << AW) - 1;
            phase = 2;
        end else if (rsp_ready) begin
            m_ptr = (m_id + 1) % N;
            phase = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (i == last_g) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                set_data(i, W'($urandom));
            end else if (!req_valid[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    set_data(i, W'($urandom));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        int exp3 [5] = '{0, 1, 2, 3, 0};
        int k;
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) m_tot[i] = 0;

        @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_sum", 32'(rsp_sum), 0);
        check("rst_ready", 32'(req_ready), 0);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // All four requesting with a ready consumer: strict rotation.
        req_valid = '1;
        for (int i = 0; i < N; i++) set_data(i, W'($urandom));
        rsp_ready = 1'b1;
        gq.delete();
        gt.delete();
        for (int c = 0; c < 15; c++) begin
            tick();
            if (last_g >= 0) set_data(last_g, W'($urandom));
        end
        check("t3_count", 32'(gq.size() >= 5), 1);
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            check("t3_order", 32'(gq[i]), 32'(exp3[i]));
            if (i > 0) check("t3_gap", 32'(gt[i] - gt[i-1]), 3);
        end
        drain();

        // Lone requester 2 with 10110.
        req_valid = 4'b0100;
        set_data(2, 5'b10110);
        tick();
        check("t2_grant", 32'(last_g), 2);
        req_valid = '0;
        tick();
        #1;
        check("t2_valid", 32'(rsp_valid), 1);
        check("t2_id", 32'(rsp_id), 2);
        check("t2_sum", 32'(rsp_sum), 3);
        tick();
        drain();

        // Full vector then empty vector from requester 0.
        req_valid = 4'b0001;
        set_data(0, 5'b11111);
        k = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (last_g == 0) begin
                k++;
                if (k == 1) set_data(0, 5'b00000);
                else req_valid = '0;
            end
            #1;
            if (rsp_valid && k == 1) check("t4_full", 32'(rsp_sum), 5);
            if (rsp_valid && k == 2) check("t4_empty", 32'(rsp_sum), 0);
        end
        drain();

        // Backpressure: hold the result for 10 cycles.
        req_valid = 4'b1000;
        set_data(3, W'($urandom));
        rsp_ready = 1'b0;
        for (int c = 0; c < 6 && phase != 2; c++) begin
            tick();
            if (last_g >= 0) req_valid = 4'b0111;
        end
        check("t5_reached", 32'(phase), 2);
        for (int c = 0; c < 10; c++) tick();
        rsp_ready = 1'b1;
        tick();
        check("t5_done", 32'(phase), 0);
        drain();

        // Reset while a result is being offered.
        req_valid = 4'b0100;
        set_data(2, 5'b11011);
        rsp_ready = 1'b0;
        for (int c = 0; c < 6 && phase != 2; c++) begin
            tick();
            if (last_g >= 0) req_valid = '0;
        end
        tick();
        check("t1_inresp", 32'(rsp_valid), 1);
        req_valid = '1;
        #2 reset_n = 1'b0;
        #1;
        check("t1_valid", 32'(rsp_valid), 0);
        check("t1_id", 32'(rsp_id), 0);
        check("t1_sum", 32'(rsp_sum), 0);
        check("t1_ready", 32'(req_ready), 0);
`ifdef POPCNT_ACCUM_EN
        check("t1_total", 32'(rsp_total), 0);
`endif
        req_valid = '0;
        #1 reset_n = 1'b1;
        phase = 0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_tot[i] = 0;
        @(negedge clk);
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        check("t1_regrant", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        drain();

`ifdef POPCNT_ACCUM_EN
        // Saturating running total for requester 1.
        req_valid = 4'b0010;
        set_data(1, 5'b11111);
        k = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (last_g == 1) begin
                k++;
                if (k == 2) req_valid = '0;
            end
            #1;
            if (rsp_valid && k == 1) check("t6_first", 32'(rsp_total), 5);
            if (rsp_valid && k == 2) check("t6_sat", 32'(rsp_total), 7);
        end
        drain();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
